// File: rtl/flow_ctrl_fsm_n.sv
// flow_ctrl_fsm_n: multi-FIFO flow-control FSM driving per-source pause/continue requests.
// Optional: define FLOW_CTRL_AUTOCLR_EN to let clear_err (with no FIFO full) return ERROR to INIT.
module flow_ctrl_fsm_n #(
    parameter int N_FIFO    = 5,
    parameter int N_SRC     = 4,
    parameter int MIN_PAUSE = 2,
    parameter int IW        = $clog2(N_FIFO)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enb,
    input  logic              iniciar,
    input  logic              clear_err,
    input  logic [N_FIFO-1:0] almost_full,
    input  logic [N_FIFO-1:0] full,
    input  logic [N_FIFO-1:0] almost_empty,
    input  logic [N_FIFO-1:0] empty,
    output logic [N_SRC-1:0]  pausa,
    output logic [N_SRC-1:0]  continuar,
    output logic              error_full,
    output logic [IW-1:0]     err_idx,
    output logic              idle
);

    localparam int            CW      = (MIN_PAUSE > 1) ? $clog2(MIN_PAUSE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MIN_PAUSE - 1);

    typedef enum logic [6:0] {
        ST_RESET    = 7'b0000001,
        ST_INIT     = 7'b0000010,
        ST_IDLE     = 7'b0000100,
        ST_ACTIVE   = 7'b0001000,
        ST_PAUSE    = 7'b0010000,
        ST_CONTINUE = 7'b0100000,
        ST_ERROR    = 7'b1000000
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_cnt;
    logic [N_SRC-1:0]  r_pausa;
    logic [N_SRC-1:0]  r_continuar;
    logic              r_error_full;
    logic              r_idle;
    logic [IW-1:0]     r_err_idx;

    logic              w_f;
    logic              w_af;
    logic              w_daf;
    logic              w_e;
    logic              w_ae;
    logic              w_dwell_done;
    logic              w_hold;
    logic              w_clr;
    logic [IW-1:0]     w_low_idx;
    logic [N_FIFO-N_SRC-1:0] w_unused_ae;

    assign w_f          = |full;
    assign w_af         = |almost_full;
    assign w_daf        = |almost_full[N_FIFO-1:N_SRC];
    assign w_e          = &empty;
    assign w_ae         = |almost_empty[N_SRC-1:0];
    assign w_dwell_done = (r_cnt >= CNT_MAX);
    assign w_unused_ae  = almost_empty[N_FIFO-1:N_SRC];

`ifndef FLOW_CTRL_AUTOCLR_EN
    logic w_unused_clear_err;
    assign w_unused_clear_err = clear_err;
`endif

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        w_clr  = 1'b0;
        case (r_state)
            ST_RESET:    w_next = ST_INIT;
            ST_INIT:     if (iniciar) w_next = ST_IDLE;
            ST_IDLE: begin
                if (w_f)       w_next = ST_ERROR;
                else if (!w_e) w_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (w_f)       w_next = ST_ERROR;
                else if (w_af) w_next = ST_PAUSE;
                else if (w_e)  w_next = ST_IDLE;
                else if (w_ae) w_next = ST_CONTINUE;
            end
            ST_PAUSE: begin
                if (w_f)                         w_next = ST_ERROR;
                else if (w_dwell_done && !w_af)  w_next = ST_ACTIVE;
            end
            ST_CONTINUE: w_next = w_f ? ST_ERROR : ST_ACTIVE;
            ST_ERROR: begin
`ifdef FLOW_CTRL_AUTOCLR_EN
                if (clear_err && !w_f) begin
                    w_next = ST_INIT;
                    w_clr  = 1'b1;
                end
`endif
            end
            default:     w_next = ST_RESET;
        endcase
    end

    // Scanning downward leaves the lowest set index as the final assignment.
    always_comb begin
        w_low_idx = '0;
        for (int i = N_FIFO - 1; i >= 0; i--) begin
            if (full[i]) w_low_idx = IW'(i);
        end
    end

    // Staying in PAUSE with AF gone means the dwell is still running: keep the old mask.
    assign w_hold = (r_state == ST_PAUSE) && !w_af;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_RESET;
            r_cnt        <= '0;
            r_pausa      <= '0;
            r_continuar  <= '0;
            r_error_full <= 1'b0;
            r_idle       <= 1'b0;
            r_err_idx    <= '0;
        end else if (enb) begin
            r_state <= w_next;

            if (w_next == ST_PAUSE && r_state != ST_PAUSE)
                r_cnt <= '0;
            else if (r_state == ST_PAUSE && !w_dwell_done)
                r_cnt <= r_cnt + CW'(1);

            if (w_next == ST_PAUSE) begin
                if (!w_hold) r_pausa <= almost_full[N_SRC-1:0] | {N_SRC{w_daf}};
            end else begin
                r_pausa <= '0;
            end

            r_continuar  <= (w_next == ST_CONTINUE) ? almost_empty[N_SRC-1:0] : '0;
            r_idle       <= (w_next == ST_IDLE);
            r_error_full <= (w_next == ST_ERROR);

            if (w_next == ST_ERROR && r_state != ST_ERROR)
                r_err_idx <= w_low_idx;
            else if (w_clr)
                r_err_idx <= '0;
        end
    end

    assign pausa      = r_pausa;
    assign continuar  = r_continuar;
    assign error_full = r_error_full;
    assign idle       = r_idle;
    assign err_idx    = r_err_idx;

endmodule

// File: tb/tb_flow_ctrl_fsm_n.sv
// tb_flow_ctrl_fsm_n: directed and randomized checks of flow_ctrl_fsm_n against a behavioural model.
// Build with FLOW_CTRL_AUTOCLR_EN defined to exercise the error auto-clear variant.
module tb_flow_ctrl_fsm_n;

    localparam int N_FIFO    = 5;
    localparam int N_SRC     = 4;
    localparam int MIN_PAUSE = 2;
    localparam int IW        = $clog2(N_FIFO);

    logic              clk = 1'b0;
    logic              rst;
    logic              enb;
    logic              iniciar;
    logic              clear_err;
    logic [N_FIFO-1:0] almost_full;
    logic [N_FIFO-1:0] full;
    logic [N_FIFO-1:0] almost_empty;
    logic [N_FIFO-1:0] empty;
    logic [N_SRC-1:0]  pausa;
    logic [N_SRC-1:0]  continuar;
    logic              error_full;
    logic [IW-1:0]     err_idx;
    logic              idle;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    flow_ctrl_fsm_n #(
        .N_FIFO   (N_FIFO),
        .N_SRC    (N_SRC),
        .MIN_PAUSE(MIN_PAUSE),
        .IW       (IW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enb         (enb),
        .iniciar     (iniciar),
        .clear_err   (clear_err),
        .almost_full (almost_full),
        .full        (full),
        .almost_empty(almost_empty),
        .empty       (empty),
        .pausa       (pausa),
        .continuar   (continuar),
        .error_full  (error_full),
        .err_idx     (err_idx),
        .idle        (idle)
    );

    // Behavioural model: the mode the controller is in and how many cycles it has spent pausing.
    typedef enum {M_RESET, M_INIT, M_IDLE, M_ACTIVE, M_PAUSE, M_CONT, M_ERROR} mode_t;

    mode_t            m_mode = M_RESET;
    int               m_paused_cycles = 0;
    logic [N_SRC-1:0] m_pausa = '0;
    logic [N_SRC-1:0] m_cont  = '0;
    logic             m_idle  = 1'b0;
    logic             m_err   = 1'b0;
    logic [IW-1:0]    m_idx   = '0;

    task automatic model_step();
        bit    any_full, any_af, down_af, all_empty, src_ae;
        mode_t nx;
        any_full  = (full != '0);
        any_af    = (almost_full != '0);
        down_af   = (almost_full[N_FIFO-1:N_SRC] != '0);
        all_empty = (empty == '1);
        src_ae    = (almost_empty[N_SRC-1:0] != '0);
        if (rst) begin
            m_mode = M_RESET; m_paused_cycles = 0;
            m_pausa = '0; m_cont = '0; m_idle = 1'b0; m_err = 1'b0; m_idx = '0;
            return;
        end
        if (!enb) return;
        nx = m_mode;
        case (m_mode)
            M_RESET:  nx = M_INIT;
            M_INIT:   if (iniciar) nx = M_IDLE;
            M_IDLE:   nx = any_full ? M_ERROR : (all_empty ? M_IDLE : M_ACTIVE);
            M_ACTIVE: nx = any_full ? M_ERROR : any_af ? M_PAUSE : all_empty ? M_IDLE
                         : src_ae ? M_CONT : M_ACTIVE;
            M_PAUSE:  nx = any_full ? M_ERROR
                         : (m_paused_cycles >= MIN_PAUSE && !any_af) ? M_ACTIVE : M_PAUSE;
            M_CONT:   nx = any_full ? M_ERROR : M_ACTIVE;
            M_ERROR: begin
`ifdef FLOW_CTRL_AUTOCLR_EN
                if (clear_err && !any_full) nx = M_INIT;
`endif
            end
            default:  nx = M_RESET;
        endcase
        if (nx == M_PAUSE) begin
            if (!(m_mode == M_PAUSE && !any_af))
                m_pausa = almost_full[N_SRC-1:0] | (down_af ? {N_SRC{1'b1}} : {N_SRC{1'b0}});
        end else begin
            m_pausa = '0;
        end
        m_cont = (nx == M_CONT) ? almost_empty[N_SRC-1:0] : '0;
        m_idle = (nx == M_IDLE);
        m_err  = (nx == M_ERROR);
        if (nx == M_ERROR && m_mode != M_ERROR) begin
            for (int i = 0; i < N_FIFO; i++) begin
                if (full[i]) begin
                    m_idx = IW'(i);
                    break;
                end
            end
        end
        if (m_mode == M_ERROR && nx == M_INIT) m_idx = '0;
        m_paused_cycles = (nx == M_PAUSE) ? ((m_mode == M_PAUSE) ? m_paused_cycles + 1 : 1) : 0;
        m_mode = nx;
    endtask

    // One clock: advance the model on the pre-edge inputs, then settle past the edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        enb = 1'b1; iniciar = 1'b0; clear_err = 1'b0;
        almost_full = '0; full = '0; almost_empty = '0; empty = '0;
    endtask

    task automatic go_active();
        quiet_inputs();
        rst = 1'b1; cycle(); cycle();
        rst = 1'b0; cycle();
        iniciar = 1'b1; cycle();
        iniciar = 1'b0; cycle();
    endtask

    task automatic test_reset();
        quiet_inputs();
        rst = 1'b1; cycle(); cycle();
        checks++;
        if ({pausa, continuar, error_full, idle, err_idx} !== '0) begin
            errors++;
            $display("FAIL reset_hold: got pausa=%b cont=%b err=%b idle=%b idx=%0d, want all 0",
                     pausa, continuar, error_full, idle, err_idx);
        end
        rst = 1'b0; cycle();
        checks++;
        if ({pausa, continuar, error_full, idle, err_idx} !== '0) begin
            errors++;
            $display("FAIL reset_init: got pausa=%b cont=%b err=%b idle=%b idx=%0d, want all 0",
                     pausa, continuar, error_full, idle, err_idx);
        end
    endtask

    task automatic test_start_active();
        iniciar = 1'b1; empty = '1; cycle();
        checks++;
        if (idle !== 1'b1) begin
            errors++; $display("FAIL start_idle: got idle=%b, want 1", idle);
        end
        iniciar = 1'b0; empty = '0; cycle();
        checks++;
        if (idle !== 1'b0 || {pausa, continuar, error_full} !== '0) begin
            errors++;
            $display("FAIL start_active: got idle=%b pausa=%b cont=%b err=%b, want all 0",
                     idle, pausa, continuar, error_full);
        end
    endtask

    task automatic test_source_pause();
        logic [N_SRC-1:0] want [3] = '{4'b0100, 4'b0100, 4'b0000};
        almost_full = 5'b00100;
        for (int k = 0; k < 3; k++) begin
            cycle();
            almost_full = '0;
            checks++;
            if (pausa !== want[k]) begin
                errors++;
                $display("FAIL source_pause[%0d]: got pausa=%b, want %b", k, pausa, want[k]);
            end
        end
    endtask

    task automatic test_downstream();
        almost_full = 5'b10000;
        for (int k = 0; k < 4; k++) begin
            cycle();
            checks++;
            if (pausa !== 4'b1111) begin
                errors++;
                $display("FAIL downstream_pause[%0d]: got pausa=%b, want 1111", k, pausa);
            end
        end
        almost_full = '0; cycle();
        checks++;
        if (pausa !== 4'b0000) begin
            errors++; $display("FAIL downstream_release: got pausa=%b, want 0000", pausa);
        end
    endtask

    task automatic test_continue();
        almost_empty = 5'b01001; cycle();
        almost_empty = '0;
        checks++;
        if (continuar !== 4'b1001) begin
            errors++; $display("FAIL continue_pulse: got continuar=%b, want 1001", continuar);
        end
        cycle();
        checks++;
        if (continuar !== 4'b0000) begin
            errors++; $display("FAIL continue_end: got continuar=%b, want 0000", continuar);
        end
        empty = '1; almost_empty = 5'b00001; cycle();
        checks++;
        if (idle !== 1'b1 || continuar !== 4'b0000) begin
            errors++;
            $display("FAIL empty_beats_ae: got idle=%b continuar=%b, want idle=1 continuar=0000",
                     idle, continuar);
        end
        empty = '0; almost_empty = '0; cycle();
    endtask

    task automatic test_error();
        go_active();
        full = 5'b10010; almost_full = 5'b10010; cycle();
        checks++;
        if (error_full !== 1'b1 || err_idx !== 3'd1 || pausa !== '0) begin
            errors++;
            $display("FAIL error_entry: got err=%b idx=%0d pausa=%b, want err=1 idx=1 pausa=0000",
                     error_full, err_idx, pausa);
        end
        full = 5'b01001; almost_full = '0; cycle();
        checks++;
        if (error_full !== 1'b1 || err_idx !== 3'd1) begin
            errors++;
            $display("FAIL error_idx_held: got err=%b idx=%0d, want err=1 idx=1", error_full, err_idx);
        end
        full = '0; clear_err = 1'b1; enb = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++;
            if (error_full !== 1'b1 || err_idx !== 3'd1) begin
                errors++;
                $display("FAIL error_freeze[%0d]: got err=%b idx=%0d, want err=1 idx=1",
                         k, error_full, err_idx);
            end
        end
        enb = 1'b1; cycle();
        clear_err = 1'b0;
`ifdef FLOW_CTRL_AUTOCLR_EN
        checks++;
        if (error_full !== 1'b0 || err_idx !== 3'd0) begin
            errors++;
            $display("FAIL error_autoclr: got err=%b idx=%0d, want err=0 idx=0", error_full, err_idx);
        end
        iniciar = 1'b1; empty = '1; cycle();
        iniciar = 1'b0;
        checks++;
        if (idle !== 1'b1) begin
            errors++; $display("FAIL autoclr_restart: got idle=%b, want 1", idle);
        end
`else
        for (int k = 0; k < 2; k++) begin
            cycle();
            checks++;
            if (error_full !== 1'b1 || err_idx !== 3'd1) begin
                errors++;
                $display("FAIL error_sticky[%0d]: got err=%b idx=%0d, want err=1 idx=1",
                         k, error_full, err_idx);
            end
        end
`endif
        rst = 1'b1; cycle();
        rst = 1'b0;
        checks++;
        if (error_full !== 1'b0 || err_idx !== 3'd0 || idle !== 1'b0) begin
            errors++;
            $display("FAIL error_reset: got err=%b idx=%0d idle=%b, want all 0",
                     error_full, err_idx, idle);
        end
    endtask

    task automatic test_random();
        int err_cycles = 0;
        go_active();
        for (int n = 0; n < 2000; n++) begin
            rst          = ($urandom_range(0, 149) == 0) || (err_cycles > 4);
            enb          = ($urandom_range(0, 7) != 0);
            iniciar      = $urandom_range(0, 1) == 1;
            clear_err    = ($urandom_range(0, 3) == 0);
            full         = ($urandom_range(0, 59) == 0) ? N_FIFO'($urandom_range(1, 31)) : '0;
            almost_full  = ($urandom_range(0, 5) == 0) ? N_FIFO'($urandom) : '0;
            almost_empty = ($urandom_range(0, 3) == 0) ? N_FIFO'($urandom) : '0;
            empty        = ($urandom_range(0, 5) == 0) ? '1 : N_FIFO'($urandom);
            cycle();
            err_cycles = (m_mode == M_ERROR) ? err_cycles + 1 : 0;
            checks++;
            if ({pausa, continuar, idle, error_full, err_idx} !== {m_pausa, m_cont, m_idle, m_err, m_idx}) begin
                errors++;
                $display("FAIL random[%0d]: got pausa=%b cont=%b idle=%b err=%b idx=%0d, want pausa=%b cont=%b idle=%b err=%b idx=%0d",
                         n, pausa, continuar, idle, error_full, err_idx,
                         m_pausa, m_cont, m_idle, m_err, m_idx);
            end
        end
        quiet_inputs();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        quiet_inputs();
        test_reset();
        test_start_active();
        test_source_pause();
        test_downstream();
        test_continue();
        test_error();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/flow_ctrl_fsm_n.md
# flow_ctrl_fsm_n

Parametrised flow-control state machine for the multi-FIFO datapath. It watches the status flags of N_FIFO FIFOs and drives per-source `pause`/`continuar` vectors to the N_SRC upstream sources. Compared with the fixed single-bit controller, it adds:
- per-channel pause and continue,
- downstream back-pressure fan-out,
- a minimum pause dwell,
- capture of the index of the FIFO that overflowed.

## Interface
- `N_FIFO`, 5, number of monitored FIFOs; index 0..N_SRC-1 are source FIFOs, N_SRC..N_FIFO-1 are downstream FIFOs
- `N_SRC`, 4, number of upstream sources; 1 ≤ N_SRC < N_FIFO
- `MIN_PAUSE`, 2, minimum cycles spent in PAUSE; ≥ 1
- `IW`, $clog2(N_FIFO), width of `err_idx`

- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `enb`  in  1  advance enable; low freezes state, counter and outputs
- `iniciar`  in  1  start request, sampled in INIT
- `clear_err`  in  1  error clear request (used only with FLOW_CTRL_AUTOCLR_EN)
- `almost_full`  in  N_FIFO  per-FIFO almost-full flags
- `full`  in  N_FIFO  per-FIFO full flags
- `almost_empty`  in  N_FIFO  per-FIFO almost-empty flags
- `empty`  in  N_FIFO  per-FIFO empty flags
- `pausa`  out  N_SRC  per-source pause request
- `continuar`  out  N_SRC  per-source continue request
- `error_full`  out  1  overflow error indicator
- `err_idx`  out  IW  lowest index of a full FIFO at ERROR entry
- `idle`  out  1  all FIFOs empty

## Operation
- The state register is one-hot, 7 bits: RESET, INIT, IDLE, ACTIVE, PAUSE, CONTINUE, ERROR.
- Helper signals: `F = |full`, `AF = |almost_full`, `DAF = |almost_full[N_FIFO-1:N_SRC]`, `E = &empty`, `AE = |almost_empty[N_SRC-1:0]`.

Transitions are evaluated only when `enb` = 1; first matching condition wins.
- **RESET:** go to INIT.
- **INIT:**
  - `iniciar` → IDLE
  - else stay in INIT
- **ACTIVE:**
  - F → ERROR
  - AF → PAUSE
  - E → IDLE
  - AE → CONTINUE
  - else stay in ACTIVE
- **PAUSE:**
  - F → ERROR
  - pause counter < MIN_PAUSE-1, or AF → stay in PAUSE
  - else → ACTIVE
- **CONTINUE:**
  - F → ERROR
  - else → ACTIVE (single-cycle pulse state)
- **IDLE:**
  - F → ERROR
  - E → stay in IDLE
  - else → ACTIVE
- **ERROR:** stay, except as described under Configuration.

Pause counter:
- Cleared on every entry to PAUSE.
- Increments by 1 per enabled cycle while in PAUSE.
- Saturates at MIN_PAUSE-1.

Outputs are registered and reflect the state being entered:
- `pausa[i]` = (next == PAUSE) & (almost_full[i] | DAF). A downstream almost-full pauses every source.
- `continuar[i]` = (next == CONTINUE) & almost_empty[i].
- `idle` = (next == IDLE).
- `error_full` = (next == ERROR).
- `err_idx` is loaded with the lowest i having full[i]=1, only on the transition into ERROR. It holds until reset or error clear.
- Behaviour in PAUSE is defined by two cases:
  - If AF has dropped but the dwell is not yet expired, `pausa` holds its previous value.
  - When the dwell expires, `pausa` follows the formula above.

## Timing
- Inputs sampled at edge k; state and all outputs valid after edge k. Latency from flag to output is 1 cycle.
- When `rst` = 1 at an edge:
  - state = RESET, pause counter = 0
  - `pausa` = 0, `continuar` = 0, `error_full` = 0, `idle` = 0, `err_idx` = 0
- Reset takes priority over `enb` and over any state, including ERROR.
- When `enb` = 0: no state change, no counter change, outputs hold.
- Simultaneous `full` and `almost_full`: ERROR wins.
- Simultaneous E and AE: IDLE wins.
- Several FIFOs full in the same cycle: `err_idx` = lowest index.
- Reset mid-PAUSE: the counter clears; the next pause after INIT restarts the full dwell.

## Configuration
- `FLOW_CTRL_AUTOCLR_EN` defined:
  - ERROR with `clear_err` = 1 and F = 0 → INIT.
  - On that transition, `error_full` clears and `err_idx` → 0.
- Not defined:
  - `clear_err` is ignored.
  - ERROR is left only by `rst`.

## Test plan
- **Reset:** rst=1 for 2 cycles, then rst=0 → state INIT; all outputs 0; `err_idx`=0.
- **Start and active:** iniciar=1, empty=5'b11111 → `idle`=1 next cycle. Then empty=0 → `idle`=0 and state ACTIVE.
- **Source pause:** in ACTIVE, almost_full=5'b00100 for 1 cycle → `pausa`=4'b0100 for exactly MIN_PAUSE=2 cycles, then `pausa`=0.
- **Downstream back-pressure:** almost_full=5'b10000 → `pausa`=4'b1111 while held.
- **Continue:** in ACTIVE, almost_empty=5'b01001 → one-cycle `continuar`=4'b1001.
- **Error:** full=5'b10010 → `error_full`=1 and `err_idx`=1.
  - Then clear_err=1 with full=0: exits to INIT only with FLOW_CTRL_AUTOCLR_EN; otherwise stays in ERROR until rst.
  - Also check that `enb`=0 during an error freezes the state.
